fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial drain for the 8-bit synchronous FIFO: pops one byte at a time through the FIFO's read port and shifts it out as an asynchronous serial frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It sits on the read side of the FIFO, consuming `empty`/`data_out` and driving `re`, and provides the byte-stream-to-line conversion for the transmit path.

## Interface
- `CLKS_PER_BIT`, default 16, clk cycles per serial bit; legal range 2..65535 (16-bit counter).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  enable; when low, no new byte is fetched, but a frame in progress completes.
- `fifo_empty`  in  1  FIFO empty flag (combinational from FIFO).
- `fifo_data`  in  8  FIFO `data_out`, registered in the FIFO, valid the cycle after a read.
- `fifo_re`  out  1  FIFO read enable, one-cycle pulse per byte.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse after each stop bit completes.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. If `en`=1 and `fifo_empty`=0 at a rising edge, go to FETCH; otherwise stay.
- FETCH: `fifo_re`=1 for exactly this one cycle (Moore output). Unconditionally go to LOAD.
- LOAD: `fifo_data` is valid. At the edge ending LOAD, capture it into an 8-bit shift register, clear the bit counter and cycle counter, set `tx`=0, and go to START.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then drive bit 0 and go to DATA.
- DATA: each bit is held `CLKS_PER_BIT` cycles and the shift register shifts right. After bit 7's period, set `tx`=1 and go to STOP.
- STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE with `tx_done`=1 for the first IDLE cycle.
- Exactly one `fifo_re` pulse per frame. `fifo_re` is never asserted outside FETCH, so it is never issued while the FIFO is empty.
- `en` is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- Cycle counter: 16 bits, counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. Bit counter: 3 bits, 0..7.

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `fifo_re`=0, `tx_done`=0, shift register=0, counters=0.
- Let the IDLE edge that samples `fifo_empty`=0 be edge k:
  - `fifo_re` is high during cycle k..k+1.
  - `tx` falls at edge k+2.
  - The stop bit ends at edge k+2+10·`CLKS_PER_BIT`.
  - `tx_done` is high during the following cycle.
- Back-to-back frames: with data remaining and `en`=1, the next start bit falls 3 cycles after the stop bit ends (IDLE, FETCH, LOAD). `tx` stays high throughout that gap.
- `busy` rises at the edge entering FETCH and falls at the edge entering IDLE.
- Reset mid-frame: at the next edge all outputs return to their reset values. The popped byte is discarded and no further `fifo_re` is issued until the FIFO is non-empty again after reset.
- Reset has priority over every transition, including the FETCH→LOAD step.

## Test plan
Bench instantiates the FIFO and this block back-to-back with `CLKS_PER_BIT`=4.
- Reset with FIFO empty and `en`=1, held 20 cycles -> `tx`=1, `busy`=0, `fifo_re`=0 on every cycle.
- Write 0xA5 -> single `fifo_re` pulse; `tx` sequence, 4 cycles per bit, is 0 \| 1,0,1,0,0,1,0,1 \| 1; `tx_done` high exactly 40 cycles after the `tx` falling edge; `fifo_empty`=1 afterwards.
- Write 0x01, 0x80, 0xFF, 0x00 -> exactly 4 `fifo_re` pulses and 4 frames decoded by the bench receiver in that order; 3-cycle high gap between each stop bit end and the next start bit.
- Hold `en`=0 with 2 bytes queued -> no `fifo_re` and `tx`=1; raise `en` -> both bytes sent. Drop `en` during the first frame's DATA state -> that frame completes and the second byte is not fetched.
- Assert `rst` for one cycle during data bit 3 of a frame -> next cycle `tx`=1, `busy`=0, `tx_done` never pulses for that frame, and no `fifo_re` follows.
- `CLKS_PER_BIT`=2 rerun of the 0xA5 case -> 20-cycle frame with correct bit order.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial drain for the 8-bit synchronous FIFO: pops one byte per frame and
// shifts it out as 8N1 (start, 8 data bits LSB first, stop), idle-high line.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [7:0]  shreg;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic        bit_end;

  always_comb begin
    bit_end = (clk_cnt == LAST_CLK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      fifo_re <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      fifo_re <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (en && !fifo_empty) begin
            state   <= FETCH;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        // FIFO registers data_out on the edge ending FETCH; it is valid in LOAD.
        FETCH: state <= LOAD;
        LOAD: begin
          shreg   <= fifo_data;
          clk_cnt <= '0;
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        // shreg runs one bit ahead of tx: shreg[0] is always the next bit to send.
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
